// File: rtl/output_interface_pkg.sv
// Shared constants and types for the nibble readout path that drives the board LEDs.
package output_interface_pkg;

   localparam int INP_DATA_LEN = 1076;
   localparam int OUT_DATA_LEN = INP_DATA_LEN;
   localparam int NIBBLE_W     = 4;
   localparam int OUT_CNT_W    = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nib_cnt(input int data_len);
      return data_len / NIBBLE_W;
   endfunction

endpackage

// File: rtl/output_interface_if.sv
// Result hand-off from the core's result register to the LED readout block.
interface output_interface_if
   import output_interface_pkg::*;
#(
   parameter int DATA_LEN = OUT_DATA_LEN,
   parameter int CNT_W    = OUT_CNT_W
) ();

   // result_valid is a level with no ready: the consumer captures on its 0->1
   // transition, and result_data/result_len must be stable while it is high.
   logic                result_valid;
   logic [DATA_LEN-1:0] result_data;
   logic [CNT_W-1:0]    result_len;

   modport master (
      output result_valid,
      output result_data,
      output result_len
   );

   modport slave (
      input result_valid,
      input result_data,
      input result_len
   );

endinterface

// File: rtl/output_interface_rise_detect.sv
// One-cycle pulse on each 0->1 transition of a level input sampled on clk.
module rise_detect #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic pulse
);

   logic prev;

   // RST_VAL = 1 keeps a level that is already high at reset release from counting as an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev <= RST_VAL;
      end else begin
         prev <= level;
      end
   end

   assign pulse = level & ~prev;

endmodule

// File: rtl/output_interface.sv
// Latches a core result and steps through it one nibble at a time on the LEDs, MSB nibble first.
module output_interface
   import output_interface_pkg::*;
#(
   parameter int DATA_LEN = OUT_DATA_LEN,
   parameter int CNT_W    = OUT_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rot_event,
   input  logic                  PB1,
   output_interface_if.slave     res,
   output logic [NIBBLE_W-1:0]   leds,
   output logic                  led_valid,
   output logic [CNT_W-1:0]      nib_idx,
   output logic                  busy,
   output logic                  done,
   output state_t                state
);

   localparam int              NIB_CNT   = nib_cnt(DATA_LEN);
   localparam logic [CNT_W-1:0] NIB_CNT_C = CNT_W'(NIB_CNT);

   logic rot_rise;
   logic pb_rise;
   logic valid_rise;

   rise_detect #(.RST_VAL(1'b1)) u_rot_rise (
      .clk   (clk),
      .rst_n (rst_n),
      .level (rot_event),
      .pulse (rot_rise)
   );

   rise_detect #(.RST_VAL(1'b1)) u_pb_rise (
      .clk   (clk),
      .rst_n (rst_n),
      .level (PB1),
      .pulse (pb_rise)
   );

   rise_detect #(.RST_VAL(1'b0)) u_valid_rise (
      .clk   (clk),
      .rst_n (rst_n),
      .level (res.result_valid),
      .pulse (valid_rise)
   );

   logic [DATA_LEN-1:0] buffer;
   logic [CNT_W-1:0]    len;
   logic [CNT_W-1:0]    norm_len;
   logic [CNT_W-1:0]    last_idx;
   logic [CNT_W+1:0]    bit_off;
   logic [NIBBLE_W-1:0] cur_nib;

   // Zero requests the full vector; anything longer than the vector is clipped to it.
   always_comb begin
      norm_len = res.result_len;
      if ((res.result_len == '0) || (res.result_len > NIB_CNT_C)) begin
         norm_len = NIB_CNT_C;
      end
   end

   assign last_idx = len - CNT_W'(1);
   assign bit_off  = {nib_idx, 2'b00};
   assign cur_nib  = buffer[DATA_LEN - 1 - int'(bit_off) -: NIBBLE_W];
   assign busy     = (state == SHOW);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         leds      <= '0;
         led_valid <= 1'b0;
         nib_idx   <= '0;
         done      <= 1'b0;
         buffer    <= '0;
         len       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (valid_rise) begin
                  buffer  <= res.result_data;
                  len     <= norm_len;
                  nib_idx <= '0;
                  state   <= SHOW;
               end
            end

            SHOW: begin
               // The displayed nibble trails nib_idx by one cycle.
               leds      <= cur_nib;
               led_valid <= 1'b1;
               if (pb_rise) begin
                  nib_idx <= '0;
               end else if (rot_rise) begin
                  if (nib_idx == last_idx) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     led_valid <= 1'b0;
                     leds      <= '0;
                  end else begin
                     nib_idx <= nib_idx + CNT_W'(1);
                  end
               end
            end

            DONE: begin
               if (valid_rise) begin
                  buffer  <= res.result_data;
                  len     <= norm_len;
                  nib_idx <= '0;
                  done    <= 1'b0;
                  state   <= SHOW;
               end else if (pb_rise) begin
                  nib_idx <= '0;
                  done    <= 1'b0;
                  state   <= SHOW;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_output_interface.sv
// Bench for output_interface: a 16-bit instance for directed sequences and a full-size one for a long readout.
module tb_output_interface;
   import output_interface_pkg::*;

   localparam int SW = 16;
   localparam int SC = 3;
   localparam int BW = 1076;
   localparam int BC = 9;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------- small instance ----------------
   logic          s_rot, s_pb;
   logic [3:0]    s_leds;
   logic          s_led_valid, s_busy, s_done;
   logic [SC-1:0] s_nib_idx;
   state_t        s_state;

   output_interface_if #(.DATA_LEN(SW), .CNT_W(SC)) s_if ();

   output_interface #(.DATA_LEN(SW), .CNT_W(SC)) dut_s (
      .clk       (clk),
      .rst_n     (rst_n),
      .rot_event (s_rot),
      .PB1       (s_pb),
      .res       (s_if.slave),
      .leds      (s_leds),
      .led_valid (s_led_valid),
      .nib_idx   (s_nib_idx),
      .busy      (s_busy),
      .done      (s_done),
      .state     (s_state)
   );

   // ---------------- full-size instance ----------------
   logic          b_rot, b_pb;
   logic [3:0]    b_leds;
   logic          b_led_valid, b_busy, b_done;
   logic [BC-1:0] b_nib_idx;
   state_t        b_state;
   logic [BW-1:0] bd;

   output_interface_if #(.DATA_LEN(BW), .CNT_W(BC)) b_if ();

   output_interface #(.DATA_LEN(BW), .CNT_W(BC)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .rot_event (b_rot),
      .PB1       (b_pb),
      .res       (b_if.slave),
      .leds      (b_leds),
      .led_valid (b_led_valid),
      .nib_idx   (b_nib_idx),
      .busy      (b_busy),
      .done      (b_done),
      .state     (b_state)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [9:0]  exp_q[$];
   logic [13:0] exp_b_q[$];

   function automatic logic [9:0] mk(input bit bsy, input bit dn, input bit lv,
                                     input logic [2:0] idx, input logic [3:0] l);
      return {bsy, dn, lv, idx, l};
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, actual, required);
      end
   endtask

   // Small monitor: every change of {busy,done,led_valid,nib_idx,leds} must match the next expected entry.
   logic [9:0] s_prev = '0;
   always @(negedge clk) begin
      logic [9:0] cur;
      logic [9:0] exp_v;
      cur = {s_busy, s_done, s_led_valid, s_nib_idx, s_leds};
      if (rst_n !== 1'bx && cur !== s_prev) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL small_unexpected actual=%h required=no_change", cur);
         end else begin
            exp_v = exp_q.pop_front();
            if (cur !== exp_v) begin
              errors++;
              $display("FAIL small_seq actual=%h required=%h", cur, exp_v);
            end
         end
         s_prev = cur;
      end
   end

   // Full-size monitor: a nibble is compared one cycle after its index appears; done rising is its own event.
   logic [BC-1:0] b_last = '1;
   bit            b_pend = 1'b0;
   logic          b_prev_done = 1'b0;
   always @(negedge clk) begin
      logic [13:0] cur;
      logic [13:0] exp_v;
      cur = {b_done, b_nib_idx, b_leds};
      if (b_pend) begin
         checks++;
         b_pend = 1'b0;
         if (exp_b_q.size() == 0) begin
            errors++;
            $display("FAIL big_unexpected actual=%h required=none", cur);
         end else begin
            exp_v = exp_b_q.pop_front();
            if (cur !== exp_v) begin
               errors++;
               $display("FAIL big_nibble actual=%h required=%h", cur, exp_v);
            end
         end
      end
      if (b_led_valid !== 1'b1) begin
         b_last = '1;
      end else if (b_nib_idx != b_last) begin
         b_last = b_nib_idx;
         b_pend = 1'b1;
      end
      if (b_done === 1'b1 && b_prev_done !== 1'b1) begin
         checks++;
         if (exp_b_q.size() == 0) begin
            errors++;
            $display("FAIL big_unexpected_done actual=%h required=none", cur);
         end else begin
            exp_v = exp_b_q.pop_front();
            if (cur !== exp_v) begin
               errors++;
               $display("FAIL big_done actual=%h required=%h", cur, exp_v);
            end
         end
      end
      b_prev_done = b_done;
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic s_rot_pulse();
      s_rot = 1'b1; tick(1);
      s_rot = 1'b0; tick(1);
   endtask

   task automatic s_pb_pulse();
      s_pb = 1'b1; tick(1);
      s_pb = 1'b0; tick(1);
   endtask

   task automatic s_both_pulse();
      s_pb = 1'b1; s_rot = 1'b1; tick(1);
      s_pb = 1'b0; s_rot = 1'b0; tick(1);
   endtask

   task automatic s_capture(input logic [15:0] d, input logic [2:0] l);
      s_if.result_valid = 1'b0; tick(1);
      s_if.result_data  = d;
      s_if.result_len   = l;
      s_if.result_valid = 1'b1; tick(2);
   endtask

   task automatic b_rot_pulse();
      b_rot = 1'b1; tick(1);
      b_rot = 1'b0; tick(1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      s_rot = 1'b0; s_pb = 1'b0;
      s_if.result_valid = 1'b0; s_if.result_data = '0; s_if.result_len = '0;
      b_rot = 1'b0; b_pb = 1'b0;
      b_if.result_valid = 1'b0; b_if.result_data = '0; b_if.result_len = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("reset_small_outputs", 32'({s_busy, s_done, s_led_valid, s_nib_idx, s_leds}), 32'h0);
      check("reset_small_state", 32'(s_state), 32'(IDLE));
      check("reset_big_outputs", 32'({b_busy, b_done, b_led_valid, b_leds}), 32'h0);
      check("reset_big_idx", 32'(b_nib_idx), 32'h0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // Full readout of A5C3; result_valid stays high throughout
      exp_q.push_back(mk(1, 0, 0, 0, 4'h0));
      exp_q.push_back(mk(1, 0, 1, 0, 4'hA));
      s_capture(16'hA5C3, 3'd0);
      exp_q.push_back(mk(1, 0, 1, 1, 4'hA)); exp_q.push_back(mk(1, 0, 1, 1, 4'h5));
      s_rot_pulse();
      exp_q.push_back(mk(1, 0, 1, 2, 4'h5)); exp_q.push_back(mk(1, 0, 1, 2, 4'hC));
      s_rot_pulse();
      exp_q.push_back(mk(1, 0, 1, 3, 4'hC)); exp_q.push_back(mk(1, 0, 1, 3, 4'h3));
      s_rot_pulse();
      exp_q.push_back(mk(0, 1, 0, 3, 4'h0));
      s_rot_pulse();
      tick(3);
      check("done_state", 32'(s_state), 32'(DONE));
      s_rot_pulse();
      tick(2);

      // PB1 in DONE returns to the first nibble of the retained buffer
      exp_q.push_back(mk(1, 0, 0, 0, 4'h0)); exp_q.push_back(mk(1, 0, 1, 0, 4'hA));
      s_pb_pulse();
      exp_q.push_back(mk(1, 0, 1, 1, 4'hA)); exp_q.push_back(mk(1, 0, 1, 1, 4'h5));
      s_rot_pulse();
      exp_q.push_back(mk(1, 0, 1, 2, 4'h5)); exp_q.push_back(mk(1, 0, 1, 2, 4'hC));
      s_rot_pulse();
      // PB1 and rot together at index 2: rewind wins
      exp_q.push_back(mk(1, 0, 1, 0, 4'hC)); exp_q.push_back(mk(1, 0, 1, 0, 4'hA));
      s_both_pulse();
      tick(2);

      // New valid pulse during SHOW is ignored
      s_if.result_valid = 1'b0; tick(1);
      s_if.result_data = 16'h1234; s_if.result_len = 3'd2;
      s_if.result_valid = 1'b1; tick(3);
      exp_q.push_back(mk(1, 0, 1, 1, 4'hA)); exp_q.push_back(mk(1, 0, 1, 1, 4'h5));
      s_rot_pulse();
      exp_q.push_back(mk(1, 0, 1, 2, 4'h5)); exp_q.push_back(mk(1, 0, 1, 2, 4'hC));
      s_rot_pulse();
      exp_q.push_back(mk(1, 0, 1, 3, 4'hC)); exp_q.push_back(mk(1, 0, 1, 3, 4'h3));
      s_rot_pulse();
      exp_q.push_back(mk(0, 1, 0, 3, 4'h0));
      s_rot_pulse();
      tick(2);

      // Same pulse in DONE recaptures; partial length of 2
      exp_q.push_back(mk(1, 0, 0, 0, 4'h0)); exp_q.push_back(mk(1, 0, 1, 0, 4'h1));
      s_capture(16'h1234, 3'd2);
      exp_q.push_back(mk(1, 0, 1, 1, 4'h1)); exp_q.push_back(mk(1, 0, 1, 1, 4'h2));
      s_rot_pulse();
      exp_q.push_back(mk(0, 1, 0, 1, 4'h0));
      s_rot_pulse();
      tick(2);

      // Length 7 saturates to 4 nibbles
      exp_q.push_back(mk(1, 0, 0, 0, 4'h0)); exp_q.push_back(mk(1, 0, 1, 0, 4'h9));
      s_capture(16'h9876, 3'd7);
      exp_q.push_back(mk(1, 0, 1, 1, 4'h9)); exp_q.push_back(mk(1, 0, 1, 1, 4'h8));
      s_rot_pulse();
      exp_q.push_back(mk(1, 0, 1, 2, 4'h8)); exp_q.push_back(mk(1, 0, 1, 2, 4'h7));
      s_rot_pulse();
      exp_q.push_back(mk(1, 0, 1, 3, 4'h7)); exp_q.push_back(mk(1, 0, 1, 3, 4'h6));
      s_rot_pulse();
      exp_q.push_back(mk(0, 1, 0, 3, 4'h0));
      s_rot_pulse();
      tick(2);

      // Asynchronous reset mid-SHOW at index 2, rot held high across release
      exp_q.push_back(mk(1, 0, 0, 0, 4'h0)); exp_q.push_back(mk(1, 0, 1, 0, 4'hA));
      s_capture(16'hA5C3, 3'd0);
      exp_q.push_back(mk(1, 0, 1, 1, 4'hA)); exp_q.push_back(mk(1, 0, 1, 1, 4'h5));
      s_rot_pulse();
      exp_q.push_back(mk(1, 0, 1, 2, 4'h5)); exp_q.push_back(mk(1, 0, 1, 2, 4'hC));
      s_rot_pulse();
      tick(1);
      exp_q.push_back(mk(0, 0, 0, 0, 4'h0));
      s_rot = 1'b1;
      s_if.result_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", 32'({s_busy, s_done, s_led_valid, s_nib_idx, s_leds}), 32'h0);
      check("async_reset_state", 32'(s_state), 32'(IDLE));
      tick(2);
      rst_n = 1'b1;
      tick(3);
      exp_q.push_back(mk(1, 0, 0, 0, 4'h0)); exp_q.push_back(mk(1, 0, 1, 0, 4'hA));
      s_capture(16'hA5C3, 3'd0);
      tick(3);
      check("rot_held_no_advance", 32'(s_nib_idx), 32'h0);
      s_rot = 1'b0; tick(1);
      exp_q.push_back(mk(1, 0, 1, 1, 4'hA)); exp_q.push_back(mk(1, 0, 1, 1, 4'h5));
      s_rot_pulse();
      tick(2);

      // Full-size readout of random data
      for (int i = 0; i < BW; i++) bd[i] = 1'($urandom_range(0, 1));
      for (int n = 0; n < BW / 4; n++) exp_b_q.push_back({1'b0, BC'(n), bd[BW - 1 - 4 * n -: 4]});
      exp_b_q.push_back({1'b1, BC'(BW / 4 - 1), 4'h0});
      b_if.result_data = bd;
      b_if.result_len  = '0;
      b_if.result_valid = 1'b1;
      tick(3);
      for (int n = 0; n < BW / 4 - 1; n++) b_rot_pulse();
      tick(1);
      check("big_last_idx", 32'(b_nib_idx), 32'(BW / 4 - 1));
      check("big_last_leds", 32'(b_leds), 32'(bd[3:0]));
      b_rot_pulse();
      tick(4);
      check("big_done", 32'({b_done, b_busy, b_led_valid}), 32'h4);

      check("small_queue_drained", 32'(exp_q.size()), 32'h0);
      check("big_queue_drained", 32'(exp_b_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
